// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Front end for the simple I2C master/slave block. Host requests are queued
// in a small FIFO and issued one at a time on the block's wr/addr/din inputs.
// Those inputs are held until the qualifying done pulse arrives or the
// per-command timeout expires. Exactly one response per command is returned
// on a valid/ready interface, in command order.
module i2c_cmd_sequencer #(
  parameter int DEPTH       = 4,    // command FIFO entries, power of two >= 2
  parameter int SKIP_DONE   = 1,    // done pulses discarded after each issue
  parameter int TIMEOUT_CYC = 1024  // cycles from issue to qualifying done
) (
  input  logic                   clk,
  input  logic                   rst,
  // host command side
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  // host response side
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [6:0]             rsp_addr,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  // I2C block side
  output logic                   i2c_wr,
  output logic [6:0]             i2c_addr,
  output logic [7:0]             i2c_din,
  input  logic [7:0]             i2c_datard,
  input  logic                   i2c_done,
  // status
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int DCW = (SKIP_DONE > 0) ? $clog2(SKIP_DONE + 1) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [LW-1:0]  LEVEL_FULL = LW'(DEPTH);
  localparam logic [DCW-1:0] SKIP_LAST  = DCW'(SKIP_DONE);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t            fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            push, pop;
  cmd_t            head;
  state_t          state_q;

  // cmd_ready comes from registered level only, so a pop while full frees the
  // slot for the host one cycle later.
  assign cmd_ready  = (level_q != LEVEL_FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && (level_q != '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || (level_q != '0);

  // Next occupancy: push and pop together leave the level unchanged.
  always_comb begin
    // NOTE: default assignment first so every path drives level_d and no latch is inferred.
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO storage write; entries are only read after being written.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and level alone define which entries are valid.
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
    end
  end

  // FIFO pointers and level; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / wait / respond sequencer
  // ---------------------------------------------------------------------------
  logic [DCW-1:0] done_cnt_q;
  logic [TCW-1:0] tmo_cnt_q;
  logic           cur_wr_q;
  logic [6:0]     cur_addr_q;
  logic           rsp_valid_q, rsp_wr_q, rsp_err_q;
  logic [6:0]     rsp_addr_q;
  logic [7:0]     rsp_data_q;
  logic           i2c_wr_q;
  logic [6:0]     i2c_addr_q;
  logic [7:0]     i2c_din_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign i2c_wr    = i2c_wr_q;
  assign i2c_addr  = i2c_addr_q;
  assign i2c_din   = i2c_din_q;

  // Sequencer FSM with all host and I2C outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      cur_wr_q    <= 1'b0;
      cur_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      i2c_wr_q    <= 1'b0;
      i2c_addr_q  <= '0;
      i2c_din_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            i2c_wr_q   <= head.wr;
            i2c_addr_q <= head.addr;
            i2c_din_q  <= head.data;
            cur_wr_q   <= head.wr;
            cur_addr_q <= head.addr;
            done_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            state_q    <= S_WAIT;
          end else begin
            // addr/din hold; wr drops so the free-running block cannot
            // repeat the last write while nothing is pending.
            i2c_wr_q <= 1'b0;
          end
        end

        S_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + TCW'(1);
          // The qualifying done beats a coincident timeout.
          if (i2c_done && (done_cnt_q == SKIP_LAST)) begin
            rsp_wr_q    <= cur_wr_q;
            rsp_addr_q  <= cur_addr_q;
            rsp_data_q  <= cur_wr_q ? 8'h00 : i2c_datard;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rsp_wr_q    <= cur_wr_q;
            rsp_addr_q  <= cur_addr_q;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (i2c_done) begin
            // Stale pulse from a transaction that may have sampled the
            // previous request; never exceeds SKIP_LAST so it saturates.
            done_cnt_q <= done_cnt_q + DCW'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
